reg_bank_mp: RTL and testbench
==============================

Name: reg_bank_mp

Overview:
- Parametrised successor to the 32x32 two-read register bank.
- Provides WIDTH x DEPTH storage with NUM_RD synchronous read ports and one byte-masked write port.
- Read data is registered, and a same-cycle write is forwarded to any read of the same address (write-first).
- After reset, a clear-sweep FSM zeroes the array one entry per cycle and raises ready when finished. Sits in the datapath as the general-purpose register file.

Parameters:
- WIDTH, 32, data width in bits; must be a multiple of 8.
- DEPTH, 32, number of registers; any value 2..256.
- NUM_RD, 2, number of independent read ports (1..4).
- AW (localparam), $clog2(DEPTH), address width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous active-low reset (0 = reset, sampled on rising clk).
- ready  output  1  high when the clear sweep is done and the bank accepts accesses.
- write  input  1  write strobe, sampled on rising clk.
- dr  input  AW  write address.
- wrdata  input  WIDTH  write data.
- wr_be  input  WIDTH/8  byte enables; bit b covers wrdata[8b+7:8b].
- sr  input  NUM_RD*AW  read addresses; port i = sr[i*AW +: AW].
- rddata  output  NUM_RD*WIDTH  registered read data; port i = rddata[i*WIDTH +: WIDTH].

Behaviour:
- FSM states: CLEAR, IDLE.
- Reset (reset==0 at a rising edge):
  - state<=CLEAR, clr_ptr<=0, ready<=0, all rddata<=0.
  - Array contents are not touched on that edge.
  - While reset stays low, clr_ptr holds at 0.
- CLEAR (reset==1):
  - Each edge writes mem[clr_ptr]<=0 and increments clr_ptr.
  - When clr_ptr==DEPTH-1 is cleared, state<=IDLE and ready<=1 on that same edge.
  - Total: DEPTH edges after the first edge with reset==1.
- During CLEAR: write is ignored, rddata is held at 0, and sr is ignored.
- Reset asserted mid-sweep or mid-operation: the sweep restarts from 0 on the next edge; no partial state survives.
- Write in IDLE:
  - If write==1 and dr<DEPTH, for each b with wr_be[b]==1: mem[dr][8b+7:8b]<=wrdata[8b+7:8b]. Other bytes keep their value.
  - wr_be==0 with write==1 is a legal no-op.
- Read in IDLE, latency 1:
  - At edge N, rddata port i <= mem[sr_i] as sampled at edge N. The value is visible after edge N and stable until edge N+1.
  - Bypass: if write==1 and dr==sr_i at edge N, port i gets the merged value (enabled bytes from wrdata, others from mem[dr]).
- Out-of-range addresses (>=DEPTH, only possible when DEPTH is not a power of two): reads return 0; writes are ignored.
- Multiple read ports on the same address each return the same value, with bypass applied identically to each.
- No combinational path from any input to any output.

Optional Feature:
- Macro REG_BANK_ZERO_R0_EN.
- When defined, register 0 is hardwired zero:
  - writes to dr==0 are discarded;
  - reads of address 0 always return 0, including the bypass case;
  - the clear sweep behaves unchanged.
- When undefined, register 0 is an ordinary register.

Test Plan:
- Reset sweep, defaults (DEPTH=32): hold reset=0 for 3 cycles, then release. Required: ready=0 for exactly 32 edges, ready=1 after the 32nd, and a subsequent read of every address returns 0.
- Fill/readback (WIDTH=32, NUM_RD=2): write mem[k]=10*k with wr_be=4'hF for k=0..31, then read sr0=k, sr1=k+1 for even k. Required: one cycle later, rddata0=10*k and rddata1=10*(k+1). With REG_BANK_ZERO_R0_EN, reg[0] reads 0.
- Byte mask: mem[5]=32'h11223344, then write wrdata=32'hAABBCCDD with wr_be=4'b0101. Required: read of 5 returns 32'h11BB33DD.
- Bypass: in the same cycle, write dr=7, wrdata=32'hDEADBEEF, wr_be=4'hF, with sr0=7 and sr1=7. Required: next cycle both ports read 32'hDEADBEEF, not the old value.
- Reset mid-sweep and mid-write:
  - Drop reset at sweep edge 10, then release. Required: ready rises only after a full 32 further edges.
  - Write during CLEAR (dr=3, data 32'h55). Required: read of 3 returns 0 once ready.
- Non-power-of-two geometry (DEPTH=20, AW=5): write dr=25 with data 32'h1234. Required: no array change, and a read with sr0=25 returns 0.

Source files
------------

// File: rtl/reg_bank_mp.sv
// reg_bank_mp -- parametrised multi-read-port register bank.
//
// WIDTH x DEPTH storage, NUM_RD registered read ports, one byte-masked write
// port. A same-cycle write to a read address is forwarded (write-first).
// After reset a clear sweep zeroes one entry per cycle, then raises ready.
//
// Optional feature: define REG_BANK_ZERO_R0_EN to hardwire register 0 to zero
// (writes to address 0 are discarded, reads of address 0 return 0).
//
// Ports:
//   clk     in   rising-edge clock
//   reset   in   synchronous active-low reset
//   ready   out  clear sweep done, bank accepts accesses
//   write   in   write strobe
//   dr      in   [AW-1:0]           write address
//   wrdata  in   [WIDTH-1:0]        write data
//   wr_be   in   [WIDTH/8-1:0]      byte enables
//   sr      in   [NUM_RD*AW-1:0]    read addresses, port i = sr[i*AW +: AW]
//   rddata  out  [NUM_RD*WIDTH-1:0] registered read data, port i = rddata[i*WIDTH +: WIDTH]

module reg_bank_mp #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int NUM_RD = 2,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     ready,
  input  logic                     write,
  input  logic [AW-1:0]            dr,
  input  logic [WIDTH-1:0]         wrdata,
  input  logic [WIDTH/8-1:0]       wr_be,
  input  logic [NUM_RD*AW-1:0]     sr,
  output logic [NUM_RD*WIDTH-1:0]  rddata
);

  localparam int NB = WIDTH / 8;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic {
    CLEAR,
    IDLE
  } state_e;

  state_e                    state_q, state_d;
  logic [AW-1:0]             clr_ptr_q, clr_ptr_d;
  logic                      ready_q, ready_d;
  logic [NUM_RD*WIDTH-1:0]   rddata_q, rddata_d;
  logic [WIDTH-1:0]          mem_q [DEPTH];

  logic                      wr_en;
  logic [WIDTH-1:0]          wr_merged;

  function automatic logic in_range(input logic [AW-1:0] a);
    return int'(a) < DEPTH;
  endfunction

  // State register, sweep pointer, ready flag and read data registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
      ready_q   <= 1'b0;
      rddata_q  <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      ready_q   <= ready_d;
      rddata_q  <= rddata_d;
    end
  end

  // Next-state logic for the clear sweep.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    ready_d   = ready_q;
    case (state_q)
      CLEAR: begin
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == LAST) begin
          state_d   = IDLE;
          ready_d   = 1'b1;
          clr_ptr_d = '0;
        end
      end
      IDLE: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = CLEAR;
        clr_ptr_d = '0;
        ready_d   = 1'b0;
      end
    endcase
  end

  // Write qualification and byte merge; the merged word feeds both the array
  // and the read bypass so forwarding always matches what gets stored.
  always_comb begin
    wr_en = (state_q == IDLE) && write && in_range(dr);
`ifdef REG_BANK_ZERO_R0_EN
    if (dr == '0) wr_en = 1'b0;
`endif
    wr_merged = mem_q[dr];
    for (int unsigned b = 0; b < NB; b++) begin
      if (wr_be[b]) wr_merged[8*b +: 8] = wrdata[8*b +: 8];
    end
  end

  // Array: sweep clears one entry per edge; array is untouched while reset is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (state_q == CLEAR) begin
        mem_q[clr_ptr_q] <= '0;
      end else if (wr_en) begin
        mem_q[dr] <= wr_merged;
      end
    end
  end

  // Read ports: zero during the sweep or for out-of-range addresses,
  // otherwise stored value with write-first forwarding.
  always_comb begin
    logic [AW-1:0]    ra;
    logic [WIDTH-1:0] word;
    rddata_d = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      ra   = sr[i*AW +: AW];
      word = '0;
      if (state_q == IDLE && in_range(ra)) begin
        word = (wr_en && dr == ra) ? wr_merged : mem_q[ra];
      end
`ifdef REG_BANK_ZERO_R0_EN
      if (ra == '0) word = '0;
`endif
      rddata_d[i*WIDTH +: WIDTH] = word;
    end
  end

  assign ready  = ready_q;
  assign rddata = rddata_q;

endmodule

// File: tb/tb_reg_bank_mp.sv
module tb_reg_bank_mp;

  localparam int W  = 32;
  localparam int D  = 32;
  localparam int NR = 2;
  localparam int AW = 5;
  localparam int D2 = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              ready, np_ready;
  logic              write, np_write;
  logic [AW-1:0]     dr, np_dr;
  logic [W-1:0]      wrdata, np_wrdata;
  logic [3:0]        wr_be, np_wr_be;
  logic [NR*AW-1:0]  sr, np_sr;
  logic [NR*W-1:0]   rddata, np_rddata;

  reg_bank_mp #(.WIDTH(W), .DEPTH(D), .NUM_RD(NR)) u_dut (
    .clk(clk), .reset(reset), .ready(ready), .write(write), .dr(dr),
    .wrdata(wrdata), .wr_be(wr_be), .sr(sr), .rddata(rddata)
  );

  reg_bank_mp #(.WIDTH(W), .DEPTH(D2), .NUM_RD(NR)) u_np (
    .clk(clk), .reset(reset), .ready(np_ready), .write(np_write), .dr(np_dr),
    .wrdata(np_wrdata), .wr_be(np_wr_be), .sr(np_sr), .rddata(np_rddata)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: plain arrays of words.
  logic [31:0] mdl    [D];
  logic [31:0] np_mdl [D2];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic bit zero_r0();
`ifdef REG_BANK_ZERO_R0_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic mdl_write(input int a, input logic [31:0] d, input logic [3:0] be);
    if (a < D && !(zero_r0() && a == 0)) mdl[a] = merge(mdl[a], d, be);
  endtask

  function automatic logic [31:0] mdl_read(input int a);
    if (a >= D) return '0;
    if (zero_r0() && a == 0) return '0;
    return mdl[a];
  endfunction

  task automatic np_mdl_write(input int a, input logic [31:0] d, input logic [3:0] be);
    if (a < D2 && !(zero_r0() && a == 0)) np_mdl[a] = merge(np_mdl[a], d, be);
  endtask

  function automatic logic [31:0] np_mdl_read(input int a);
    if (a >= D2) return '0;
    if (zero_r0() && a == 0) return '0;
    return np_mdl[a];
  endfunction

  task automatic clear_models();
    for (int k = 0; k < D; k++) mdl[k] = '0;
    for (int k = 0; k < D2; k++) np_mdl[k] = '0;
  endtask

  // Drive one cycle on the main instance and step past the edge.
  task automatic drive(input bit w, input int a, input logic [31:0] d, input logic [3:0] be,
                       input int r0, input int r1);
    write  = w;
    dr     = AW'(a);
    wrdata = d;
    wr_be  = be;
    sr     = {AW'(r1), AW'(r0)};
    @(posedge clk);
    #1;
  endtask

  task automatic np_drive(input bit w, input int a, input logic [31:0] d, input logic [3:0] be,
                          input int r0, input int r1);
    np_write  = w;
    np_dr     = AW'(a);
    np_wrdata = d;
    np_wr_be  = be;
    np_sr     = {AW'(r1), AW'(r0)};
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int e = 0; e < 3; e++) begin
      drive(1'b0, 0, '0, '0, 1, 2);
      checks++;
      if (ready !== 1'b0 || rddata !== '0) begin
        errors++;
        $display("FAIL reset_hold edge %0d: ready=%b rddata=%h, required ready=0 rddata=0", e, ready, rddata);
      end
    end
    reset = 1'b1;
    for (int e = 1; e <= D; e++) begin
      drive(1'b0, 0, '0, '0, 3, 4);
      checks++;
      if (ready !== (e == D)) begin
        errors++;
        $display("FAIL reset_sweep edge %0d: ready=%b required %b", e, ready, (e == D));
      end
      if (e < D && rddata !== '0) begin
        errors++;
        $display("FAIL reset_sweep_rd edge %0d: rddata=%h required 0", e, rddata);
      end
    end
    clear_models();
    checks++;
    if (np_ready !== 1'b1) begin
      errors++;
      $display("FAIL np_ready_after_sweep: %b required 1", np_ready);
    end
    for (int k = 0; k < D; k += 2) begin
      drive(1'b0, 0, '0, '0, k, k + 1);
      checks++;
      if (rddata[31:0] !== 32'h0 || rddata[63:32] !== 32'h0) begin
        errors++;
        $display("FAIL reset_readzero addr %0d: got %h/%h required 0/0", k, rddata[31:0], rddata[63:32]);
      end
    end
  endtask

  task automatic test_fill();
    logic [31:0] e0, e1;
    for (int k = 0; k < D; k++) begin
      drive(1'b1, k, 32'(10 * k), 4'hF, 0, 0);
      mdl_write(k, 32'(10 * k), 4'hF);
    end
    for (int k = 0; k < D; k += 2) begin
      drive(1'b0, 0, '0, '0, k, k + 1);
      e0 = (zero_r0() && k == 0) ? 32'h0 : 32'(10 * k);
      e1 = 32'(10 * (k + 1));
      checks++;
      if (rddata[31:0] !== e0 || rddata[63:32] !== e1) begin
        errors++;
        $display("FAIL fill_read k=%0d: got %h/%h required %h/%h", k, rddata[31:0], rddata[63:32], e0, e1);
      end
    end
  endtask

  task automatic test_byte_mask();
    drive(1'b1, 5, 32'h11223344, 4'hF, 0, 0);
    mdl_write(5, 32'h11223344, 4'hF);
    drive(1'b1, 5, 32'hAABBCCDD, 4'b0101, 0, 0);
    mdl_write(5, 32'hAABBCCDD, 4'b0101);
    drive(1'b0, 0, '0, '0, 5, 5);
    checks++;
    if (rddata[31:0] !== 32'h11BB33DD || rddata[63:32] !== 32'h11BB33DD) begin
      errors++;
      $display("FAIL byte_mask: got %h/%h required 11bb33dd", rddata[31:0], rddata[63:32]);
    end
    // all-zero enables with write is a no-op
    drive(1'b1, 5, 32'hFFFFFFFF, 4'h0, 0, 0);
    drive(1'b0, 0, '0, '0, 5, 6);
    checks++;
    if (rddata[31:0] !== 32'h11BB33DD || rddata[63:32] !== mdl_read(6)) begin
      errors++;
      $display("FAIL be_zero_noop: got %h/%h required 11bb33dd/%h", rddata[31:0], rddata[63:32], mdl_read(6));
    end
  endtask

  task automatic test_bypass();
    drive(1'b1, 7, 32'hDEADBEEF, 4'hF, 7, 7);
    mdl_write(7, 32'hDEADBEEF, 4'hF);
    checks++;
    if (rddata[31:0] !== 32'hDEADBEEF || rddata[63:32] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL bypass_full: got %h/%h required deadbeef", rddata[31:0], rddata[63:32]);
    end
    // partial bypass: merged bytes visible on one port, other port reads another address
    drive(1'b1, 7, 32'h00CC0011, 4'b0101, 7, 8);
    mdl_write(7, 32'h00CC0011, 4'b0101);
    checks++;
    if (rddata[31:0] !== 32'hDECCBE11 || rddata[63:32] !== mdl_read(8)) begin
      errors++;
      $display("FAIL bypass_merge: got %h/%h required deccbe11/%h", rddata[31:0], rddata[63:32], mdl_read(8));
    end
    // bypass on address 0
    drive(1'b1, 0, 32'h0BADF00D, 4'hF, 0, 0);
    mdl_write(0, 32'h0BADF00D, 4'hF);
    checks++;
    if (rddata[31:0] !== mdl_read(0) || rddata[63:32] !== mdl_read(0)) begin
      errors++;
      $display("FAIL bypass_r0: got %h/%h required %h", rddata[31:0], rddata[63:32], mdl_read(0));
    end
  endtask

  task automatic test_random();
    int a, r0, r1;
    bit w;
    logic [31:0] d, e0, e1;
    logic [3:0] be;
    for (int n = 0; n < 300; n++) begin
      w  = ($urandom_range(0, 2) != 0);
      a  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(0, D - 1);
      d  = $urandom;
      be = 4'($urandom_range(0, 15));
      r0 = ($urandom_range(0, 3) == 0) ? a : $urandom_range(0, D - 1);
      r1 = ($urandom_range(0, 3) == 0) ? a : $urandom_range(0, D - 1);
      drive(w, a, d, be, r0, r1);
      if (w) mdl_write(a, d, be);
      e0 = mdl_read(r0);
      e1 = mdl_read(r1);
      checks++;
      if (rddata[31:0] !== e0 || rddata[63:32] !== e1) begin
        errors++;
        $display("FAIL random n=%0d w=%0d a=%0d r=%0d/%0d: got %h/%h required %h/%h",
                 n, w, a, r0, r1, rddata[31:0], rddata[63:32], e0, e1);
      end
    end
  endtask

  task automatic test_mid_sweep();
    // reset asserted while a write is being presented: write must not land
    reset = 1'b0;
    drive(1'b1, 9, 32'hABCD0000, 4'hF, 0, 0);
    reset = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      drive(1'b0, 0, '0, '0, 3, 9);
      checks++;
      if (ready !== 1'b0 || rddata !== '0) begin
        errors++;
        $display("FAIL partial_sweep edge %0d: ready=%b rddata=%h required 0/0", e, ready, rddata);
      end
    end
    reset = 1'b0;
    drive(1'b0, 0, '0, '0, 0, 0);
    reset = 1'b1;
    for (int e = 1; e <= D; e++) begin
      drive(1'b1, 3, 32'h55, 4'hF, 3, 9);
      checks++;
      if (ready !== (e == D)) begin
        errors++;
        $display("FAIL restart_sweep edge %0d: ready=%b required %b", e, ready, (e == D));
      end
    end
    clear_models();
    drive(1'b0, 0, '0, '0, 3, 9);
    checks++;
    if (rddata[31:0] !== 32'h0 || rddata[63:32] !== 32'h0) begin
      errors++;
      $display("FAIL clear_write_ignored: got %h/%h required 0/0", rddata[31:0], rddata[63:32]);
    end
  endtask

  task automatic test_non_pow2();
    int n;
    n = 0;
    while (np_ready !== 1'b1 && n < 100) begin
      np_drive(1'b0, 0, '0, '0, 0, 0);
      n++;
    end
    checks++;
    if (np_ready !== 1'b1) begin
      errors++;
      $display("FAIL np_ready_timeout: ready=%b required 1", np_ready);
    end
    np_drive(1'b1, 4, 32'hCAFE, 4'hF, 0, 0);
    np_mdl_write(4, 32'hCAFE, 4'hF);
    np_drive(1'b1, 25, 32'h1234, 4'hF, 25, 25);
    np_mdl_write(25, 32'h1234, 4'hF);
    checks++;
    if (np_rddata !== '0) begin
      errors++;
      $display("FAIL np_oor_bypass: got %h required 0", np_rddata);
    end
    np_drive(1'b0, 0, '0, '0, 25, 4);
    checks++;
    if (np_rddata[31:0] !== 32'h0 || np_rddata[63:32] !== 32'hCAFE) begin
      errors++;
      $display("FAIL np_oor_read: got %h/%h required 0/0000cafe", np_rddata[31:0], np_rddata[63:32]);
    end
    for (int k = 0; k < D2; k += 2) begin
      np_drive(1'b0, 0, '0, '0, k, k + 1);
      checks++;
      if (np_rddata[31:0] !== np_mdl_read(k) || np_rddata[63:32] !== np_mdl_read(k + 1)) begin
        errors++;
        $display("FAIL np_array k=%0d: got %h/%h required %h/%h", k, np_rddata[31:0],
                 np_rddata[63:32], np_mdl_read(k), np_mdl_read(k + 1));
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    write = 1'b0; dr = '0; wrdata = '0; wr_be = '0; sr = '0;
    np_write = 1'b0; np_dr = '0; np_wrdata = '0; np_wr_be = '0; np_sr = '0;
    clear_models();
    test_reset();
    test_fill();
    test_byte_mask();
    test_bypass();
    test_random();
    test_mid_sweep();
    test_non_pow2();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
